// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: four-way round-robin arbiter driving a shared 4:1 mux.
// Grant, select and the selected data are all registered; O/O_VALID lag GNT
// by one cycle. Ownership is bounded by MAX_HOLD consecutive granted cycles.
//
// Optional build macro MUX_ARB_PRIO0_EN: requester A wins every arbitration
// point outright, B..D rotate among themselves. Without it, all four rotate.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner, GNT=0, waiting for any request
// GRANT | one requester owns the channel, HOLD_CNT counts its cycles
module mux_rr_arbiter #(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [3:0]       REQ,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    output logic [3:0]       GNT,
    output logic [1:0]       S,
    output logic [WIDTH-1:0] O,
    output logic             O_VALID
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // HOLD_CNT equal to this value marks the MAX_HOLD-th granted cycle.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       s_q, s_d;
    logic [1:0]       last_q, last_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic [WIDTH-1:0] o_q;
    logic             o_valid_q;
    logic [WIDTH-1:0] mux_data;

    logic             req_any;
    logic             release_now;
    logic [1:0]       win_idx;
    logic [1:0]       win_last;

    assign req_any     = |REQ;
    assign release_now = !REQ[s_q] || (hold_cnt_q == HOLD_LAST);

`ifdef MUX_ARB_PRIO0_EN
    // B..D rotate 1->2->3->1; last_q never points at A in this build.
    function automatic logic [1:0] next_bcd(input logic [1:0] x);
        return (x == 2'd3) ? 2'd1 : x + 2'd1;
    endfunction

    logic [1:0] cand_1, cand_2, cand_3;

    // Winner: A outright, else first of B..D after the last B..D owner.
    always_comb begin
        cand_1  = next_bcd(last_q);
        cand_2  = next_bcd(cand_1);
        cand_3  = next_bcd(cand_2);
        win_idx = 2'd0;
        if (REQ[0])           win_idx = 2'd0;
        else if (REQ[cand_1]) win_idx = cand_1;
        else if (REQ[cand_2]) win_idx = cand_2;
        else if (REQ[cand_3]) win_idx = cand_3;
        // A's wins leave the B..D rotation pointer untouched.
        win_last = (win_idx == 2'd0) ? last_q : win_idx;
    end
`else
    logic [1:0] cand;

    // Winner: first set REQ bit searching upward from last_q+1 with wrap;
    // the last owner itself comes last, so it only wins when alone.
    always_comb begin
        win_idx = 2'd0;
        cand    = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            cand = last_q + 2'(k);
            if (REQ[cand]) win_idx = cand;
        end
        win_last = win_idx;
    end
`endif

    // Next-state and next-grant decision.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        s_d        = s_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d    = GRANT;
                    gnt_d      = 4'b0001 << win_idx;
                    s_d        = win_idx;
                    last_d     = win_last;
                    hold_cnt_d = 8'd0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    if (req_any) begin
                        // Back-to-back handover, no idle cycle in between.
                        gnt_d      = 4'b0001 << win_idx;
                        s_d        = win_idx;
                        last_d     = win_last;
                        hold_cnt_d = 8'd0;
                    end else begin
                        // S keeps pointing at the previous owner.
                        state_d    = IDLE;
                        gnt_d      = 4'b0000;
                        hold_cnt_d = 8'd0;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            gnt_q      <= 4'b0000;
            s_q        <= 2'd0;
            last_q     <= 2'd3;
            hold_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            s_q        <= s_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // 4:1 data mux steered by the registered select.
    always_comb begin
        case (s_q)
            2'd0:    mux_data = A;
            2'd1:    mux_data = B;
            2'd2:    mux_data = C;
            default: mux_data = D;
        endcase
    end

    // Output data register; holds its value across non-granted cycles.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            o_q       <= '0;
            o_valid_q <= 1'b0;
        end else begin
            o_valid_q <= |gnt_q;
            if (|gnt_q) o_q <= mux_data;
        end
    end

    assign GNT     = gnt_q;
    assign S       = s_q;
    assign O       = o_q;
    assign O_VALID = o_valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: two instances (MAX_HOLD=4 and MAX_HOLD=1) share
// one set of inputs and are compared every cycle against an owner/count
// reference model, plus a directed vector table and hand-written sequences.
module tb_mux_rr_arbiter;

    localparam int W = 4;

    logic         CLK;
    logic         RST_N;
    logic [3:0]   req;
    logic [W-1:0] da, db, dc, dd;

    logic [3:0]   gnt4, gnt1;
    logic [1:0]   s4, s1;
    logic [W-1:0] o4, o1;
    logic         ov4, ov1;

    int total = 0;
    int bad   = 0;

    mux_rr_arbiter #(.WIDTH(W), .MAX_HOLD(4)) dut4 (
        .CLK(CLK), .RST_N(RST_N), .REQ(req),
        .A(da), .B(db), .C(dc), .D(dd),
        .GNT(gnt4), .S(s4), .O(o4), .O_VALID(ov4)
    );

    mux_rr_arbiter #(.WIDTH(W), .MAX_HOLD(1)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .REQ(req),
        .A(da), .B(db), .C(dc), .D(dd),
        .GNT(gnt1), .S(s1), .O(o1), .O_VALID(ov1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // owner = -1 when idle; cnt = granted cycles so far for the current owner.
    int           maxh [2] = '{4, 1};
    int           owner[2];
    int           cnt  [2];
    int           last [2];
    int           lastbcd[2];
    logic [1:0]   ms   [2];
    logic [W-1:0] mo   [2];
    logic         mov  [2];

    function automatic logic [W-1:0] dsel(input int k);
        case (k)
            0: return da;
            1: return db;
            2: return dc;
            default: return dd;
        endcase
    endfunction

    function automatic int pick(input int i);
`ifdef MUX_ARB_PRIO0_EN
        if (req[0]) return 0;
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = ((lastbcd[i] - 1 + k) % 3) + 1;
            if (req[c]) return c;
        end
        return -1;
`else
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (last[i] + k) % 4;
            if (req[c]) return c;
        end
        return -1;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            owner[i] = -1; cnt[i] = 0; last[i] = 3; lastbcd[i] = 3;
            ms[i] = 2'd0; mo[i] = '0; mov[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit take;
            int w;
            mov[i] = (owner[i] >= 0);
            if (owner[i] >= 0) mo[i] = dsel(owner[i]);
            take = (owner[i] < 0) || !req[owner[i]] || (cnt[i] == maxh[i]);
            if (take) begin
                w = pick(i);
                if (w < 0) begin
                    owner[i] = -1;
                end else begin
                    owner[i] = w; ms[i] = 2'(w); cnt[i] = 1; last[i] = w;
                    if (w != 0) lastbcd[i] = w;
                end
            end else begin
                cnt[i]++;
            end
        end
    endtask

    function automatic logic [3:0] mgnt(input int i);
        return (owner[i] < 0) ? 4'b0000 : (4'b0001 << owner[i]);
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic check_all();
        chk("gnt_h4", 32'(gnt4), 32'(mgnt(0)));
        chk("s_h4",   32'(s4),   32'(ms[0]));
        chk("o_h4",   32'(o4),   32'(mo[0]));
        chk("ov_h4",  32'(ov4),  32'(mov[0]));
        chk("gnt_h1", 32'(gnt1), 32'(mgnt(1)));
        chk("s_h1",   32'(s1),   32'(ms[1]));
        chk("o_h1",   32'(o1),   32'(mo[1]));
        chk("ov_h1",  32'(ov1),  32'(mov[1]));
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        check_all();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        #2;
        RST_N = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt4), 32'h0);
        chk("rst_s",   32'(s4),   32'h0);
        chk("rst_o",   32'(o4),   32'h0);
        chk("rst_ov",  32'(ov4),  32'h0);
        model_reset();
        RST_N = 1'b1;
    endtask

    typedef struct {
        logic [3:0]   req;
        logic [3:0]   gnt;
        logic [1:0]   s;
        logic [W-1:0] o;
        logic         ov;
    } vec_t;

    vec_t tbl[14];

    initial begin
        // inputs before edge -> MAX_HOLD=4 outputs after edge
        tbl[0]  = '{4'b0010, 4'b0010, 2'd1, 4'h0, 1'b0};
        tbl[1]  = '{4'b0010, 4'b0010, 2'd1, 4'hB, 1'b1};
        tbl[2]  = '{4'b0010, 4'b0010, 2'd1, 4'hB, 1'b1};
        tbl[3]  = '{4'b0000, 4'b0000, 2'd1, 4'hB, 1'b1};
        tbl[4]  = '{4'b0000, 4'b0000, 2'd1, 4'hB, 1'b0};
        tbl[5]  = '{4'b0001, 4'b0001, 2'd0, 4'hB, 1'b0};
        tbl[6]  = '{4'b0101, 4'b0001, 2'd0, 4'hA, 1'b1};
        tbl[7]  = '{4'b0100, 4'b0100, 2'd2, 4'hA, 1'b1};
        tbl[8]  = '{4'b0100, 4'b0100, 2'd2, 4'hC, 1'b1};
        tbl[9]  = '{4'b0100, 4'b0100, 2'd2, 4'hC, 1'b1};
        tbl[10] = '{4'b0100, 4'b0100, 2'd2, 4'hC, 1'b1};
        tbl[11] = '{4'b0100, 4'b0100, 2'd2, 4'hC, 1'b1};
        tbl[12] = '{4'b0000, 4'b0000, 2'd2, 4'hC, 1'b1};
        tbl[13] = '{4'b0000, 4'b0000, 2'd2, 4'hC, 1'b0};

        RST_N = 1'b0;
        req = 4'b0000;
        da = 4'hA; db = 4'hB; dc = 4'hC; dd = 4'hD;
        model_reset();
        repeat (2) @(negedge CLK);
        check_all();
        RST_N = 1'b1;

        // Directed table: single requester, idle return, early release.
        for (int n = 0; n < 14; n++) begin
            req = tbl[n].req;
            cycle();
            chk("tbl_gnt", 32'(gnt4), 32'(tbl[n].gnt));
            chk("tbl_s",   32'(s4),   32'(tbl[n].s));
            chk("tbl_o",   32'(o4),   32'(tbl[n].o));
            chk("tbl_ov",  32'(ov4),  32'(tbl[n].ov));
        end

        // Full contention from a fresh reset.
        do_reset();
        req = 4'b1111;
        for (int n = 1; n <= 20; n++) begin
            cycle();
`ifndef MUX_ARB_PRIO0_EN
            chk("contend_h4", 32'(gnt4), 32'(4'b0001 << (((n - 1) / 4) % 4)));
            chk("contend_h1", 32'(gnt1), 32'(4'b0001 << ((n - 1) % 4)));
`endif
            if (n >= 2) chk("contend_ov", 32'(ov4), 32'h1);
        end

        // Reset in the middle of contention; A must win first afterwards.
        do_reset();
        cycle();
        chk("post_rst_gnt", 32'(gnt4), 32'h1);

        // MAX_HOLD=1 alternation between A and C.
        do_reset();
        req = 4'b0101;
        for (int n = 1; n <= 8; n++) begin
            da = 4'($urandom); dc = 4'($urandom);
            cycle();
`ifndef MUX_ARB_PRIO0_EN
            chk("alt_gnt", 32'(gnt1), (n % 2 == 1) ? 32'h1 : 32'h4);
`endif
        end

`ifdef MUX_ARB_PRIO0_EN
        // B owns, A arrives: B runs to its limit, then A instead of C.
        do_reset();
        req = 4'b1110;
        cycle();
        chk("prio_b", 32'(gnt4), 32'h2);
        req = 4'b1111;
        for (int n = 0; n < 3; n++) begin
            cycle();
            chk("prio_hold", 32'(gnt4), 32'h2);
        end
        cycle();
        chk("prio_a", 32'(gnt4), 32'h1);
`endif

        // Randomized traffic against the model, with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            da = 4'($urandom); db = 4'($urandom);
            dc = 4'($urandom); dd = 4'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
Round-robin arbiter and sequencer for a shared 4:1 multiplexer channel. Four requesters (A..D) compete for one output path. The block arbitrates, drives the registered mux select S and the one-hot grant, and registers the selected data onto O with a valid flag. A burst-hold limit bounds ownership so no requester can starve the others.

Parameters:
WIDTH, 1, data width of each input A..D and of output O
MAX_HOLD, 4, maximum consecutive grant cycles per ownership; legal range 1..255

Ports:
CLK  input  1  single clock, rising edge
RST_N  input  1  asynchronous active-low reset
REQ  input  4  request per requester; bit0=A, bit1=B, bit2=C, bit3=D
A  input  WIDTH  data from requester 0
B  input  WIDTH  data from requester 1
C  input  WIDTH  data from requester 2
D  input  WIDTH  data from requester 3
GNT  output  4  registered one-hot grant; all zero when idle
S  output  2  registered mux select, encoding of current owner
O  output  WIDTH  registered selected data
O_VALID  output  1  O holds data from a granted cycle

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. CLK and RST_N are the only clock and reset. All state is updated on the rising edge of CLK. RST_N low clears all state immediately, with no dependence on CLK.
- Reset values: STATE=IDLE, GNT=4'b0000, S=2'b00, O=0, O_VALID=0, LAST=2'd3 (pointer to last owner), HOLD_CNT=0.
- States: IDLE and GRANT.
- Arbitration function: search REQ starting at index LAST+1 mod 4, ascending with wrap. The first set bit wins.
- IDLE:
  - If REQ==0, stay in IDLE.
  - Otherwise, at the edge: GNT=onehot(winner), S=winner, LAST=winner, HOLD_CNT=0, go to GRANT.
  - Request-to-grant latency is 1 cycle.
- GRANT, each edge:
  - HOLD_CNT increments.
  - Release when REQ[S]==0, or when HOLD_CNT==MAX_HOLD-1. HOLD_CNT==MAX_HOLD-1 marks the MAX_HOLD-th granted cycle.
- On release:
  - If any REQ bit is set, re-arbitrate in the same edge from LAST+1. The new GNT, S and LAST are loaded, HOLD_CNT=0, and the block stays in GRANT. Handover is back-to-back with no idle cycle.
  - The current owner is eligible only if no other requester is asserted.
  - If REQ==0, go to IDLE with GNT=0. S holds its last value.
- Data path: each edge, O<=mux(S) of A/B/C/D using the pre-edge S, and O_VALID<=|GNT (pre-edge). O and O_VALID therefore lag GNT by exactly 1 cycle. When O_VALID=0, O holds its last value.
- Simultaneous events:
  - The owner dropping REQ on the same cycle its hold limit is reached counts as a single release.
  - New requests arriving during a grant wait for release. No preemption in the base configuration.
- MAX_HOLD=1: ownership rotates every cycle while several requesters are active.
- Reset mid-grant: GNT, O_VALID and O clear immediately. After reset, the first grant follows from LAST=3, so A has top priority.
- GNT is always one-hot or zero. S always equals the index of the GNT bit while GNT is non-zero.

Optional Feature:
MUX_ARB_PRIO0_EN
- Defined: requester A (REQ[0]) is fixed highest priority at every arbitration point, in IDLE and on release. B..D rotate round-robin among themselves, using LAST restricted to 1..3. There is still no mid-grant preemption. A's hold limit still applies, but when REQ[0] stays high A is re-granted immediately.
- Undefined: pure 4-way round-robin as described in Behaviour.

Test Plan:
- Reset: RST_N low mid-run with REQ=4'b1111 -> GNT=0, S=0, O=0 and O_VALID=0 immediately (asynchronous). After release with REQ=4'b1111, the first GNT=4'b0001.
- Single requester: REQ=4'b0010 held for 3 cycles, B=1, MAX_HOLD=4 -> GNT=4'b0010 and S=1 one edge later. O_VALID=1 and O=1 one edge after GNT. GNT returns to 0 one edge after REQ drops.
- Full contention: REQ=4'b1111 constant, MAX_HOLD=4 -> grant order A,B,C,D,A, each exactly 4 cycles, no GNT=0 gap. O_VALID stays 1 throughout.
- Early release: A owns the grant and drops REQ[0] after 2 cycles while REQ[2] is set -> next edge GNT=4'b0100, S=2, HOLD_CNT restarts.
- MAX_HOLD=1 with REQ=4'b0101 -> GNT alternates 0001/0100 every cycle. O alternates between A and C one cycle delayed.
- With MUX_ARB_PRIO0_EN defined: REQ=4'b1110 with B owning, then REQ[0] rises -> B keeps the grant to its limit, then GNT=4'b0001 rather than C.
